// File: rtl/gen_nonlinear_part_seq.sv
// gen_nonlinear_part_seq
// Sequential producer of the AND-monomial (non-linear) terms of a decomposed
// carry-lookahead adder. Block i of n holds the ANF monomials of carry c_i.
// Block i is {b[i-1] & blk(i-1), a[i-1] & blk(i-1), a[i-1] & b[i-1]}, where
// blk(0) is c_in. One block is written per cycle. The registered operands are
// presented alongside n so a combinational linear stage can form the sum.
module gen_nonlinear_part_seq #(
  parameter  int NBIT = 7,
  localparam int NNL  = 2**(NBIT+2) - NBIT - 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            c_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] out_a,
  output logic [NBIT-1:0] out_b,
  output logic            out_c_in,
  output logic [NNL-1:0]  n
);

  localparam int KW = $clog2(NBIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            accept_s;
  logic [KW-1:0]   k_r;
  logic [NNL-1:0]  calc_n_s;
  logic [NNL-1:0]  mask_s;

  // Every block is formed in parallel from the registered operands and the
  // previous block already stored in n; mask_s selects the one block that
  // the counter says is due this cycle, so only that block changes.
  for (genvar gi = 1; gi <= NBIT; gi++) begin : g_blk
    localparam int B  = 2**(gi+1) - gi - 3;
    localparam int L  = 2**(gi+1) - 1;
    localparam int LP = 2**gi - 1;
    localparam int BP = 2**gi - gi - 2;

    logic [LP-1:0] prev_s;

    if (gi == 1) begin : g_first
      assign prev_s = out_c_in;
    end else begin : g_rest
      assign prev_s = n[BP +: LP];
    end

    assign calc_n_s[B +: L] = {({LP{out_b[gi-1]}} & prev_s),
                               ({LP{out_a[gi-1]}} & prev_s),
                               (out_a[gi-1] & out_b[gi-1])};
    assign mask_s[B +: L]   = {L{k_r == KW'(gi)}};
  end

  // Next-state decode; input acceptance only ever happens in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = CALC;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (k_r == KW'(NBIT)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, handshake flags, operand capture and block-by-block fill of n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_a     <= {NBIT{1'b0}};
      out_b     <= {NBIT{1'b0}};
      out_c_in  <= 1'b0;
      n         <= {NNL{1'b0}};
      k_r       <= {KW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      in_ready  <= (state_nxt_s == IDLE);
      out_valid <= (state_nxt_s == DONE);
      if (accept_s) begin
        out_a    <= a;
        out_b    <= b;
        out_c_in <= c_in;
        n        <= {NNL{1'b0}};
        k_r      <= KW'(1);
      end else if (state_r == CALC) begin
        n <= (n & ~mask_s) | (calc_n_s & mask_s);
        if (k_r != KW'(NBIT)) begin
          k_r <= k_r + KW'(1);
        end else begin
          k_r <= k_r;
        end
      end else begin
        n   <= n;
        k_r <= k_r;
      end
    end
  end

endmodule

// File: tb/tb_gen_nonlinear_part_seq.sv
// Directed self-checking bench for gen_nonlinear_part_seq (NBIT=7 and NBIT=2).
module tb_gen_nonlinear_part_seq;

  localparam int NBIT  = 7;
  localparam int NNL   = 2**(NBIT+2) - NBIT - 4;
  localparam int NBIT2 = 2;
  localparam int NNL2  = 2**(NBIT2+2) - NBIT2 - 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NBIT-1:0] a = '0;
  logic [NBIT-1:0] b = '0;
  logic            c_in = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NBIT-1:0] out_a;
  logic [NBIT-1:0] out_b;
  logic            out_c_in;
  logic [NNL-1:0]  n;

  logic             in_valid2 = 1'b0;
  logic             in_ready2;
  logic [NBIT2-1:0] a2 = '0;
  logic [NBIT2-1:0] b2 = '0;
  logic             c_in2 = 1'b0;
  logic             out_valid2;
  logic             out_ready2 = 1'b0;
  logic [NBIT2-1:0] out_a2;
  logic [NBIT2-1:0] out_b2;
  logic             out_c_in2;
  logic [NNL2-1:0]  n2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gen_nonlinear_part_seq #(.NBIT(NBIT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c_in(out_c_in), .n(n)
  );

  gen_nonlinear_part_seq #(.NBIT(NBIT2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .c_in(c_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_a(out_a2), .out_b(out_b2), .out_c_in(out_c_in2), .n(n2)
  );

  // Reference monomial vector built straight from the block definition.
  function automatic logic [NNL-1:0] model_n(input logic [NBIT-1:0] ma,
                                             input logic [NBIT-1:0] mb,
                                             input logic mc);
    logic [NNL-1:0] r;
    int base, pbase, plen;
    r = '0;
    r[0] = ma[0] & mb[0];
    r[1] = ma[0] & mc;
    r[2] = mb[0] & mc;
    for (int i = 2; i <= NBIT; i++) begin
      base  = 2**(i+1) - i - 3;
      pbase = 2**i - i - 2;
      plen  = 2**i - 1;
      r[base] = ma[i-1] & mb[i-1];
      for (int j = 0; j < plen; j++) begin
        r[base+1+j]      = ma[i-1] & r[pbase+j];
        r[base+1+plen+j] = mb[i-1] & r[pbase+j];
      end
    end
    return r;
  endfunction

  // XOR of block i of a DUT vector.
  function automatic logic blk_xor(input logic [NNL-1:0] v, input int i);
    logic x;
    int base, len;
    x = 1'b0;
    base = 2**(i+1) - i - 3;
    len  = 2**(i+1) - 1;
    for (int j = 0; j < len; j++) x = x ^ v[base+j];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (n !== '0)           begin errors++; $display("FAIL reset_n: got %h want 0", n); end
    checks++; if ({out_a, out_b, out_c_in} !== '0) begin errors++; $display("FAIL reset_ops: got %h want 0", {out_a, out_b, out_c_in}); end
    checks++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || n2 !== '0) begin
      errors++; $display("FAIL reset_dut2: got rdy=%b vld=%b n=%h want 1 0 0", in_ready2, out_valid2, n2);
    end
  endtask

  // Accept one operation and wait for out_valid; leaves the DUT in DONE.
  task automatic start_op(input logic [NBIT-1:0] va, input logic [NBIT-1:0] vb, input logic vc);
    int lat;
    a = va; b = vb; c_in = vc; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL op_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    a = ~va; b = ~vb; c_in = ~vc;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++; if (lat != NBIT) begin errors++; $display("FAIL op_latency: got %0d want %0d", lat, NBIT); end
  endtask

  task automatic check_result(input logic [NBIT-1:0] va, input logic [NBIT-1:0] vb, input logic vc);
    logic [NNL-1:0] exp_n;
    logic [NBIT:0]  sum;
    logic [NBIT:0]  lo;
    exp_n = model_n(va, vb, vc);
    checks++; if (n !== exp_n) begin errors++; $display("FAIL op_n a=%h b=%h c=%b: got %h want %h", va, vb, vc, n, exp_n); end
    checks++; if ({out_a, out_b, out_c_in} !== {va, vb, vc}) begin
      errors++; $display("FAIL op_operands: got %h want %h", {out_a, out_b, out_c_in}, {va, vb, vc});
    end
    sum = {1'b0, va} + {1'b0, vb} + {{NBIT{1'b0}}, vc};
    checks++; if (n[2:0] !== {vb[0] & vc, va[0] & vc, va[0] & vb[0]}) begin
      errors++; $display("FAIL op_block1: got %b want %b", n[2:0], {vb[0] & vc, va[0] & vc, va[0] & vb[0]});
    end
    for (int i = 1; i <= NBIT; i++) begin
      lo = ({1'b0, va} & ((8'd1 << i) - 8'd1)) + ({1'b0, vb} & ((8'd1 << i) - 8'd1)) + {{NBIT{1'b0}}, vc};
      checks++; if (blk_xor(n, i) !== lo[i]) begin
        errors++; $display("FAIL op_carry%0d a=%h b=%h c=%b: got %b want %b", i, va, vb, vc, blk_xor(n, i), lo[i]);
      end
    end
    checks++; if (blk_xor(n, NBIT) !== sum[NBIT]) begin errors++; $display("FAIL op_cout: got %b want %b", blk_xor(n, NBIT), sum[NBIT]); end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL op_handshake: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [NBIT-1:0] va [6] = '{7'h7F, 7'h55, 7'h00, 7'h7F, 7'h12, 7'h40};
    logic [NBIT-1:0] vb [6] = '{7'h01, 7'h2A, 7'h00, 7'h7F, 7'h34, 7'h40};
    logic            vc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 6; t++) begin
      start_op(va[t], vb[t], vc[t]);
      check_result(va[t], vb[t], vc[t]);
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [NNL-1:0] held;
    start_op(7'h5A, 7'h33, 1'b1);
    held = n;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      a = 7'(i * 5); b = 7'(i * 3); c_in = i[1];
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || n !== held) begin
        errors++; $display("FAIL bp_hold cyc=%0d: got vld=%b rdy=%b nchg=%b want 1 0 0", i, out_valid, in_ready, n !== held);
      end
    end
    in_valid = 1'b0;
    check_result(7'h5A, 7'h33, 1'b1);
    finish_op();
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_accept: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    a = 7'h6B; b = 7'h1D; c_in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || n !== '0) begin
      errors++; $display("FAIL midreset: got rdy=%b vld=%b n=%h want 1 0 0", in_ready, out_valid, n);
    end
    for (int i = 0; i < NBIT + 2; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_result: got %b want 0", out_valid); end
    end
    start_op(7'h2C, 7'h71, 1'b0);
    check_result(7'h2C, 7'h71, 1'b0);
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [NBIT-1:0] va [4] = '{7'h11, 7'h7E, 7'h3C, 7'h65};
    logic [NBIT-1:0] vb [4] = '{7'h22, 7'h03, 7'h3C, 7'h1B};
    logic            vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int sent, got, cyc, last;
    sent = 0; got = 0; last = -1;
    in_valid = 1'b1; out_ready = 1'b1;
    a = va[0]; b = vb[0]; c_in = vc[0];
    for (cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (out_valid === 1'b1) begin
        checks++; if (n !== model_n(va[got], vb[got], vc[got]) || out_a !== va[got] || out_b !== vb[got]) begin
          errors++; $display("FAIL b2b_result%0d: got %h want %h", got, n, model_n(va[got], vb[got], vc[got]));
        end
        if (last >= 0) begin
          checks++; if (cyc - last != NBIT + 2) begin errors++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last, NBIT + 2); end
        end
        last = cyc;
        got++;
      end
      if (in_ready === 1'b1 && sent < 4) sent++;
      tick();
      if (sent < 4) begin a = va[sent]; b = vb[sent]; c_in = vc[sent]; end
      else begin a = 7'h00; b = 7'h00; c_in = 1'b0; end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_nbit2();
    logic [NBIT2-1:0] va [3] = '{2'b11, 2'b11, 2'b00};
    logic [NBIT2-1:0] vb [3] = '{2'b01, 2'b11, 2'b00};
    logic             vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [NNL2-1:0]  en [3] = '{10'h011, 10'h3FF, 10'h000};
    logic             co [3] = '{1'b1, 1'b1, 1'b0};
    int lat;
    for (int t = 0; t < 3; t++) begin
      a2 = va[t]; b2 = vb[t]; c_in2 = vc[t]; in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0; a2 = ~va[t]; b2 = ~vb[t];
      lat = 0;
      while (out_valid2 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      checks++; if (lat != NBIT2) begin errors++; $display("FAIL n2_latency: got %0d want %0d", lat, NBIT2); end
      checks++; if (n2 !== en[t]) begin errors++; $display("FAIL n2_value%0d: got %h want %h", t, n2, en[t]); end
      checks++; if ((^n2[9:3]) !== co[t]) begin errors++; $display("FAIL n2_cout%0d: got %b want %b", t, ^n2[9:3], co[t]); end
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_nbit2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
